// File: rtl/pe_operand_feeder.sv
// -----------------------------------------------------------------------------
// pe_operand_feeder
//   Producer side of the PE operand interface. Buffers (weight, activation)
//   pairs from the operand loader in a small FIFO and streams exactly i_len of
//   them into one pe MAC, one pair per cycle. Zeros are driven to the PE on
//   every cycle that carries no pair, so the PE accumulator is left unchanged.
//   o_done tells the result reader that the PE result is final.
//
// Configuration macro:
//   FEEDER_ZERO_SKIP_EN - when defined, a popped pair whose weight or
//                         activation is zero still counts toward the vector
//                         length but is issued as a bubble (o_pe_valid=0,
//                         data 0). o_last still marks the final slot.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   i_start       in   start a vector (sampled only in IDLE)
//   i_len         in   pairs in the vector, latched on accepted i_start
//   i_valid       in   upstream pair valid
//   i_weight      in   upstream weight
//   i_activation  in   upstream activation
//   o_ready       out  FIFO can accept a pair (not full)
//   o_weight      out  weight to pe, 0 when not issuing
//   o_activation  out  activation to pe, 0 when not issuing
//   o_pe_valid    out  outputs carry a real pair this cycle
//   o_last        out  final pair slot of the vector is on the outputs
//   o_busy        out  FSM not IDLE
//   o_done        out  one-cycle pulse, vector complete
// -----------------------------------------------------------------------------
module pe_operand_feeder #(
  parameter int WEIGHT_W = 4,
  parameter int ACT_W    = 8,
  parameter int DEPTH    = 8,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_valid,
  input  logic [WEIGHT_W-1:0] i_weight,
  input  logic [ACT_W-1:0]    i_activation,
  output logic                o_ready,
  output logic [WEIGHT_W-1:0] o_weight,
  output logic [ACT_W-1:0]    o_activation,
  output logic                o_pe_valid,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [WEIGHT_W-1:0] w_mem_r [DEPTH];
  logic [ACT_W-1:0]    a_mem_r [DEPTH];
  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic [WEIGHT_W-1:0] rd_w_s;
  logic [ACT_W-1:0]    rd_a_s;

  // Sequencer
  state_t              state_r;
  state_t              state_nxt_s;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    len_nxt_s;
  logic [LEN_W-1:0]    cnt_r;
  logic [LEN_W-1:0]    cnt_nxt_s;
  logic [LEN_W-1:0]    cnt_inc_s;
  logic                last_pop_s;
  logic                issue_s;

  // Registered outputs
  logic [WEIGHT_W-1:0] o_weight_r;
  logic [ACT_W-1:0]    o_activation_r;
  logic                o_pe_valid_r;
  logic                o_last_r;
  logic                o_busy_r;
  logic                o_done_r;

`ifdef FEEDER_ZERO_SKIP_EN
  // A pair with either operand zero contributes nothing to the MAC.
  function automatic logic pair_is_zero(input logic [WEIGHT_W-1:0] w,
                                        input logic [ACT_W-1:0]    a);
    return (w == {WEIGHT_W{1'b0}}) || (a == {ACT_W{1'b0}});
  endfunction
`endif

  // Full when the index bits match but the wrap bits differ.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  // No push-through when full: a same-cycle pop does not free a slot for the push.
  assign push_s  = i_valid && !full_s;
  assign rd_w_s  = w_mem_r[rd_ptr_r[AW-1:0]];
  assign rd_a_s  = a_mem_r[rd_ptr_r[AW-1:0]];
  assign cnt_inc_s = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};

  // FIFO data storage (data needs no reset; pointers decide validity)
  always_ff @(posedge clk) begin
    if (push_s) begin
      w_mem_r[wr_ptr_r[AW-1:0]] <= i_weight;
      a_mem_r[wr_ptr_r[AW-1:0]] <= i_activation;
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Next-state, length latch, pop and pair-count decisions
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    cnt_nxt_s   = cnt_r;
    pop_s       = 1'b0;
    last_pop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != {LEN_W{1'b0}}) begin
            len_nxt_s   = i_len;
            cnt_nxt_s   = {LEN_W{1'b0}};
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // An empty FIFO is a bubble: nothing popped, count holds.
        if (!empty_s) begin
          pop_s     = 1'b1;
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == len_r) begin
            last_pop_s  = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Decide whether the popped pair is actually presented to the PE
  always_comb begin
    issue_s = pop_s;
`ifdef FEEDER_ZERO_SKIP_EN
    if (pop_s && pair_is_zero(rd_w_s, rd_a_s)) begin
      issue_s = 1'b0;
    end else begin
      issue_s = pop_s;
    end
`endif
  end

  // FSM state, length and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      len_r   <= {LEN_W{1'b0}};
      cnt_r   <= {LEN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output registers: a pair popped at an edge appears right after that edge.
  // o_done is delayed from the DONE state so it lands one cycle after o_last,
  // i.e. once the PE has accumulated the final product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_weight_r     <= {WEIGHT_W{1'b0}};
      o_activation_r <= {ACT_W{1'b0}};
      o_pe_valid_r   <= 1'b0;
      o_last_r       <= 1'b0;
      o_busy_r       <= 1'b0;
      o_done_r       <= 1'b0;
    end else begin
      o_weight_r     <= issue_s ? rd_w_s : {WEIGHT_W{1'b0}};
      o_activation_r <= issue_s ? rd_a_s : {ACT_W{1'b0}};
      o_pe_valid_r   <= issue_s;
      o_last_r       <= last_pop_s;
      o_busy_r       <= (state_nxt_s != ST_IDLE);
      o_done_r       <= (state_r == ST_DONE);
    end
  end

  assign o_ready      = !full_s;
  assign o_weight     = o_weight_r;
  assign o_activation = o_activation_r;
  assign o_pe_valid   = o_pe_valid_r;
  assign o_last       = o_last_r;
  assign o_busy       = o_busy_r;
  assign o_done       = o_done_r;

endmodule

// File: tb/tb_pe_operand_feeder.sv
module tb_pe_operand_feeder;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [7:0] i_len;
  logic       i_valid;
  logic [3:0] i_weight;
  logic [7:0] i_activation;
  logic       o_ready;
  logic [3:0] o_weight;
  logic [7:0] o_activation;
  logic       o_pe_valid;
  logic       o_last;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int errors = 0;
  int acc    = 0;  // model of the pe accumulator

  pe_operand_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_valid      (i_valid),
    .i_weight     (i_weight),
    .i_activation (i_activation),
    .o_ready      (o_ready),
    .o_weight     (o_weight),
    .o_activation (o_activation),
    .o_pe_valid   (o_pe_valid),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, last, weight, activation}
  function automatic logic [13:0] obs();
    return {o_pe_valid, o_last, o_weight, o_activation};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    acc = acc + int'(o_weight) * int'(o_activation);
  endtask

  task automatic push(input logic [3:0] w, input logic [7:0] a);
    i_valid = 1'b1; i_weight = w; i_activation = a;
    step();
    i_valid = 1'b0;
  endtask

  task automatic start(input logic [7:0] len);
    i_start = 1'b1; i_len = len;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_len = 8'd0; i_valid = 1'b0;
    i_weight = 4'd0; i_activation = 8'd0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_done, obs()} !== {1'b1, 1'b0, 1'b0, 14'd0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h",
               {o_ready, o_busy, o_done, obs()}, {1'b1, 1'b0, 1'b0, 14'd0});
    end
    // mid-stream reset
    push(4'd1, 8'd2); push(4'd3, 8'd4); push(4'd5, 8'd6);
    start(8'd3);
    step();
    checks++;
    if (obs() !== {1'b1, 1'b0, 4'd1, 8'd2}) begin
      errors++;
      $display("FAIL reset_pre_issue: got %h expected %h", obs(), {1'b1, 1'b0, 4'd1, 8'd2});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_busy, o_done, obs()} !== {1'b1, 1'b0, 1'b0, 14'd0}) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h",
               {o_ready, o_busy, o_done, obs()}, {1'b1, 1'b0, 1'b0, 14'd0});
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({o_busy, o_done, o_pe_valid} !== 3'b000) begin
        errors++;
        $display("FAIL reset_after_release: got %b expected 000", {o_busy, o_done, o_pe_valid});
      end
    end
  endtask

  task automatic test_preload();
    acc = 0;
    for (int k = 1; k <= 5; k++) push(4'(k), 8'(k));
    start(8'd5);
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (obs() !== {1'b1, (k == 5), 4'(k), 8'(k)}) begin
        errors++;
        $display("FAIL preload_issue_%0d: got %h expected %h", k, obs(), {1'b1, (k == 5), 4'(k), 8'(k)});
      end
    end
    step();
    checks++;
    if ({o_done, obs()} !== {1'b1, 14'd0}) begin
      errors++;
      $display("FAIL preload_done: got %h expected %h", {o_done, obs()}, {1'b1, 14'd0});
    end
    checks++;
    if (acc !== 55) begin
      errors++;
      $display("FAIL preload_result: got %0d expected 55", acc);
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 8; k++) push(4'(k), 8'(16 + k));
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", o_ready);
    end
    push(4'd9, 8'd99);
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_9th: got %b expected 0", o_ready);
    end
    start(8'd8);
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs() !== {1'b1, (k == 8), 4'(k), 8'(16 + k)}) begin
        errors++;
        $display("FAIL full_issue_%0d: got %h expected %h", k, obs(), {1'b1, (k == 8), 4'(k), 8'(16 + k)});
      end
    end
    step();
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL full_done: got %b expected 1", o_done);
    end
    // 9th pair must have been dropped: a new vector starves
    start(8'd1);
    step();
    checks++;
    if (obs() !== 14'd0) begin
      errors++;
      $display("FAIL full_dropped: got %h expected %h", obs(), 14'd0);
    end
    push(4'd3, 8'd3);
    step();
    checks++;
    if (obs() !== {1'b1, 1'b1, 4'd3, 8'd3}) begin
      errors++;
      $display("FAIL full_after_drop: got %h expected %h", obs(), {1'b1, 1'b1, 4'd3, 8'd3});
    end
    step();
  endtask

  task automatic test_starvation();
    logic [13:0] exp_tab [7];
    acc = 0;
    exp_tab[0] = {1'b1, 1'b0, 4'd2, 8'd10};
    exp_tab[1] = {1'b1, 1'b0, 4'd3, 8'd11};
    exp_tab[2] = 14'd0;
    exp_tab[3] = 14'd0;
    exp_tab[4] = 14'd0;
    exp_tab[5] = {1'b1, 1'b0, 4'd4, 8'd12};
    exp_tab[6] = {1'b1, 1'b1, 4'd5, 8'd13};
    push(4'd2, 8'd10); push(4'd3, 8'd11);
    start(8'd4);
    for (int i = 0; i < 7; i++) begin
      i_valid = (i == 4) || (i == 5);
      i_weight = (i == 4) ? 4'd4 : 4'd5;
      i_activation = (i == 4) ? 8'd12 : 8'd13;
      step();
      checks++;
      if (obs() !== exp_tab[i]) begin
        errors++;
        $display("FAIL starve_cycle_%0d: got %h expected %h", i, obs(), exp_tab[i]);
      end
    end
    i_valid = 1'b0;
    step();
    checks++;
    if ({o_done, obs()} !== {1'b1, 14'd0}) begin
      errors++;
      $display("FAIL starve_done: got %h expected %h", {o_done, obs()}, {1'b1, 14'd0});
    end
    checks++;
    if (acc !== 166) begin
      errors++;
      $display("FAIL starve_result: got %0d expected 166", acc);
    end
  endtask

  task automatic test_len_zero();
    push(4'd7, 8'd7);
    start(8'd0);
    checks++;
    if ({o_busy, o_done, obs()} !== {1'b1, 1'b0, 14'd0}) begin
      errors++;
      $display("FAIL len0_busy: got %h expected %h", {o_busy, o_done, obs()}, {1'b1, 1'b0, 14'd0});
    end
    step();
    checks++;
    if ({o_busy, o_done, obs()} !== {1'b0, 1'b1, 14'd0}) begin
      errors++;
      $display("FAIL len0_done: got %h expected %h", {o_busy, o_done, obs()}, {1'b0, 1'b1, 14'd0});
    end
    start(8'd2);
    step();
    checks++;
    if (obs() !== {1'b1, 1'b0, 4'd7, 8'd7}) begin
      errors++;
      $display("FAIL len0_no_pop: got %h expected %h", obs(), {1'b1, 1'b0, 4'd7, 8'd7});
    end
    // start during RUN must be ignored (len stays 2)
    i_start = 1'b1; i_len = 8'd5;
    step();
    i_start = 1'b0;
    checks++;
    if ({o_busy, obs()} !== {1'b1, 14'd0}) begin
      errors++;
      $display("FAIL run_start_ignored: got %h expected %h", {o_busy, obs()}, {1'b1, 14'd0});
    end
    push(4'd6, 8'd6);
    step();
    checks++;
    if (obs() !== {1'b1, 1'b1, 4'd6, 8'd6}) begin
      errors++;
      $display("FAIL run_start_last: got %h expected %h", obs(), {1'b1, 1'b1, 4'd6, 8'd6});
    end
    step();
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL run_start_done: got %b expected 1", o_done);
    end
  endtask

  task automatic test_zero_skip();
    logic [13:0] exp_tab [3];
    acc = 0;
`ifdef FEEDER_ZERO_SKIP_EN
    exp_tab[0] = 14'd0;
    exp_tab[1] = {1'b1, 1'b0, 4'd2, 8'd4};
    exp_tab[2] = {1'b0, 1'b1, 4'd0, 8'd0};
`else
    exp_tab[0] = {1'b1, 1'b0, 4'd0, 8'd3};
    exp_tab[1] = {1'b1, 1'b0, 4'd2, 8'd4};
    exp_tab[2] = {1'b1, 1'b1, 4'd5, 8'd0};
`endif
    push(4'd0, 8'd3); push(4'd2, 8'd4); push(4'd5, 8'd0);
    start(8'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== exp_tab[i]) begin
        errors++;
        $display("FAIL zskip_slot_%0d: got %h expected %h", i, obs(), exp_tab[i]);
      end
    end
    step();
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL zskip_done: got %b expected 1", o_done);
    end
    checks++;
    if (acc !== 8) begin
      errors++;
      $display("FAIL zskip_result: got %0d expected 8", acc);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_full();
    test_starvation();
    test_len_zero();
    test_zero_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
